// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request from execute,
// and the valid/ready (pc, instruction) stream towards decode.
interface fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   modport master (
      output imem_addr, out_valid, out_pc, out_instr, out_fault,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_pc, out_instr, out_fault,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, tracks one registered imem read, buffers results in a
// small FIFO for decode. Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a fault entry.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  bus
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FAULT = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [31:0]   pc_q;
   logic          req_valid_q;
   logic [31:0]   req_pc_q;
   logic [1:0]    state_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];

   logic [31:0] target_pc;
   logic        target_misaligned;
   logic        fault_active;
   logic        has_head;
   logic        pop;
   logic        pop_fifo;
   logic        pop_fault;
   logic        push;
   logic        issue;
   logic [CW:0] occupancy;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
   assign target_pc         = bus.redirect_pc;
   assign target_misaligned = |bus.redirect_pc[1:0];
`else
   logic unused_low_bits;
   assign unused_low_bits   = ^bus.redirect_pc[1:0];
   assign target_pc         = {bus.redirect_pc[31:2], 2'b00};
   assign target_misaligned = 1'b0;
`endif

   assign fault_active = (state_q == ST_FAULT);
   assign has_head     = (count_q != '0);

   assign bus.imem_addr = pc_q;
   assign bus.out_valid = (has_head | fault_active) & ~bus.redirect_valid;

   assign pop       = bus.out_valid & bus.out_ready;
   assign pop_fifo  = pop & ~fault_active;
   assign pop_fault = pop & fault_active;

   // Slots already claimed: buffered entries plus the read in flight, minus what leaves now.
   assign occupancy = {1'b0, count_q}
                    + {{CW{1'b0}}, req_valid_q}
                    - {{CW{1'b0}}, pop_fifo};

   assign issue = (state_q == ST_RUN) & ~bus.redirect_valid & (occupancy < DEPTH_V);
   assign push  = req_valid_q & ~bus.redirect_valid;

   // While faulting, pc_q still holds the offending target since nothing is issued.
   assign bus.out_pc    = fault_active ? pc_q :
                          (has_head ? fifo_pc[rd_ptr_q] : 32'h0000_0000);
   assign bus.out_instr = fault_active ? NOP_INSTR :
                          (has_head ? fifo_instr[rd_ptr_q] : 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
   assign bus.out_fault = fault_active;
`else
   assign bus.out_fault = 1'b0;
`endif

   // Control: pc, request tracking, FIFO pointers/count, fault state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         state_q     <= ST_RUN;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
      end else if (bus.redirect_valid) begin
         pc_q        <= target_pc;
         req_valid_q <= 1'b0;
         state_q     <= target_misaligned ? ST_FAULT : ST_RUN;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
      end else begin
         req_valid_q <= issue;
         if (issue) begin
            pc_q <= pc_q + 32'd4;
         end
         if (push) begin
            wr_ptr_q <= ptr_next(wr_ptr_q);
         end
         if (pop_fifo) begin
            rd_ptr_q <= ptr_next(rd_ptr_q);
         end
         case ({push, pop_fifo})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (pop_fault) begin
            state_q <= ST_HALT;
         end
      end
   end

   // Data: request address and FIFO payload; gated by issue/push, so no reset needed.
   always_ff @(posedge clk) begin
      if (issue) begin
         req_pc_q <= pc_q;
      end
      if (push) begin
         fifo_pc[wr_ptr_q]    <= req_pc_q;
         fifo_instr[wr_ptr_q] <= bus.imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector tables plus hand sequences for
// mid-run reset and misaligned redirect.
module tb_fetch_unit;

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eaddr;
      logic        efault;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   passes;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0010_0013;
      if (a == 32'h4) return 32'h0020_0093;
      return a ^ 32'h5A00_0033;
   endfunction

   // Registered instruction memory: word for the address presented this cycle appears next cycle.
   always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

   function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc,
                               input logic [31:0] eaddr, input logic efault);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
      v.epc = epc; v.eaddr = eaddr; v.efault = efault;
      return v;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      bus.out_ready      = v.rdy;
      bus.redirect_valid = v.rv;
      bus.redirect_pc    = v.rpc;
      #1;
      chk32({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.ev));
      chk32({tag, " imem_addr"}, bus.imem_addr, v.eaddr);
      if (v.ev) begin
         chk32({tag, " out_pc"}, bus.out_pc, v.epc);
         chk32({tag, " out_instr"}, bus.out_instr, v.efault ? 32'h0000_0013 : mem_word(v.epc));
         chk32({tag, " out_fault"}, 32'(bus.out_fault), 32'(v.efault));
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk32({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
      chk32({tag, " out_pc"}, bus.out_pc, 32'h0);
      chk32({tag, " out_instr"}, bus.out_instr, 32'h0);
      chk32({tag, " out_fault"}, 32'(bus.out_fault), 32'h0);
      chk32({tag, " imem_addr"}, bus.imem_addr, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t main_tbl[$];
      vec_t restart_tbl[$];
      vec_t mis_tbl[$];

      checks = 0;
      passes = 0;

      // Reset release, stream, 5-cycle stall, redirect under flow, redirect under stall, wrap.
      main_tbl.push_back(mk(1, 0, 0, 0, 32'h00, 32'h00, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 32'h00, 32'h04, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h00, 32'h08, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h04, 32'h0C, 0));
      for (int k = 0; k < 5; k++) main_tbl.push_back(mk(0, 0, 0, 1, 32'h08, 32'h10, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h08, 32'h10, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h0C, 32'h14, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h10, 32'h18, 0));
      main_tbl.push_back(mk(1, 1, 32'h40, 0, 0, 32'h1C, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h40, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h44, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h40, 32'h48, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h4C, 0));
      main_tbl.push_back(mk(0, 0, 0, 1, 32'h48, 32'h50, 0));
      main_tbl.push_back(mk(0, 0, 0, 1, 32'h48, 32'h50, 0));
      main_tbl.push_back(mk(0, 1, 32'h100, 0, 0, 32'h50, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h100, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h104, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h100, 32'h108, 0));
      main_tbl.push_back(mk(1, 1, 32'hFFFF_FFF8, 0, 0, 32'h10C, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 0, 32'hFFFF_FFF8, 0));
      main_tbl.push_back(mk(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h4, 0));
      main_tbl.push_back(mk(1, 0, 0, 1, 32'h0, 32'h8, 0));

      restart_tbl.push_back(mk(1, 0, 0, 0, 32'h00, 32'h00, 0));
      restart_tbl.push_back(mk(1, 0, 0, 0, 32'h00, 32'h04, 0));
      restart_tbl.push_back(mk(1, 0, 0, 1, 32'h00, 32'h08, 0));

      mis_tbl.push_back(mk(1, 1, 32'h42, 0, 0, 32'h0C, 0));
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_tbl.push_back(mk(0, 0, 0, 1, 32'h42, 32'h42, 1));
      mis_tbl.push_back(mk(0, 0, 0, 1, 32'h42, 32'h42, 1));
      mis_tbl.push_back(mk(1, 0, 0, 1, 32'h42, 32'h42, 1));
      mis_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h42, 0));
      mis_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h42, 0));
      mis_tbl.push_back(mk(1, 1, 32'h80, 0, 0, 32'h42, 0));
      mis_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h80, 0));
      mis_tbl.push_back(mk(1, 0, 0, 0, 0, 32'h84, 0));
      mis_tbl.push_back(mk(1, 0, 0, 1, 32'h80, 32'h88, 0));
`else
      mis_tbl.push_back(mk(0, 0, 0, 0, 0, 32'h40, 0));
      mis_tbl.push_back(mk(0, 0, 0, 0, 0, 32'h44, 0));
      mis_tbl.push_back(mk(1, 0, 0, 1, 32'h40, 32'h48, 0));
      mis_tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h4C, 0));
      mis_tbl.push_back(mk(1, 0, 0, 1, 32'h48, 32'h50, 0));
`endif

      reset              = 1'b1;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset = 1'b0;

      for (int i = 0; i < main_tbl.size(); i++) step(main_tbl[i], $sformatf("main c%0d", i));

      // Mid-run asynchronous reset while a head is valid and a read is in flight.
      @(negedge clk);
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      #1;
      chk32("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
      chk32("pre-reset imem_addr", bus.imem_addr, 32'h0C);
      reset = 1'b1;
      #1;
      check_zero_outputs("async reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < restart_tbl.size(); i++) step(restart_tbl[i], $sformatf("restart c%0d", i));
      for (int i = 0; i < mis_tbl.size(); i++) step(mis_tbl[i], $sformatf("misalign c%0d", i + 3));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
